// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32I control unit.
//   state_e        - controller states
//   aluop_e        - ALU operation class handed to alu_decoder
//   ALU_*          - ALUControl codes
//   OP_*           - opcode constants (instr[6:0])
//   RES_/SRCA_/SRCB_/IMM_* - datapath select encodings
//   imm_sel()      - immediate format for a given opcode
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_UPPER,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT,
    ALUOP_PASSB
  } aluop_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALUControl generation.
//   alu_op     - operation class chosen by the controller state
//   funct3     - instr[14:12]
//   funct7b5   - instr[30]
//   op5        - instr[5], set for R-type, clear for I-type ALU ops
//   alucontrol - ALU operation code
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_e      alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        op5,
  output logic [3:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_PASSB: alucontrol = ALU_PASSB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi carries immediate bits in instr[30], so only R-type may subtract
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style main controller for a multicycle RV32I core.
//   clk, rst                        - clock, synchronous active-high reset
//   op, funct3, funct7b5            - instruction fields
//   Zero, signedLess, unsignedLess  - ALU flags for branch resolution
//   mem_ready                       - memory completes the access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite - datapath strobes
//   ResultSrc, ALUSrcA, ALUSrcB     - datapath selects
//   ALUControl, ImmSrc              - ALU operation, immediate format
//   illegal                         - sticky unsupported-opcode flag
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        signedLess,
  input  logic        unsignedLess,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        illegal
);

  state_e state, state_next;
  aluop_e alu_op;
  logic   pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw;
  logic   taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_HALT)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = signedLess;
      3'b101:  taken = ~signedLess;
      3'b110:  taken = unsignedLess;
      3'b111:  taken = ~unsignedLess;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state;
    pcwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    alu_op       = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          irwrite_raw = 1'b1;
          pcwrite_raw = 1'b1;
          state_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI, OP_AUIPC:  state_next = S_UPPER;
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready)
          state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready)
          state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_raw = 1'b1;
        state_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = SRCA_RS1;
        alu_op      = ALUOP_SUB;
        pcwrite_raw = taken;
        state_next  = S_FETCH;
      end
      S_JALR: begin
        // target rs1+imm overwrites the DECODE-computed ALUOut, then JAL redirects
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_JAL;
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pcwrite_raw = 1'b1;
        state_next  = S_ALUWB;
      end
      S_UPPER: begin
        ALUSrcB = SRCB_IMM;
        if (op[5]) begin
          ALUSrcA = SRCA_PC;
          alu_op  = ALUOP_PASSB;
        end else begin
          ALUSrcA = SRCA_OLDPC;
        end
        state_next = S_ALUWB;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // write strobes are suppressed while reset is asserted
  assign PCWrite  = pcwrite_raw  & ~rst;
  assign MemWrite = memwrite_raw & ~rst;
  assign IRWrite  = irwrite_raw  & ~rst;
  assign RegWrite = regwrite_raw & ~rst;
  assign ImmSrc   = imm_sel(op);

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, signedLess, unsignedLess, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .signedLess(signedLess), .unsignedLess(unsignedLess),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR,
    P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_JALR, P_UPPER, P_HALT
  } phase_t;

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill;
  } out_t;

  out_t   q_exp[$];
  phase_t q_ph[$];
  int     checks = 0;
  int     errors = 0;

  logic [6:0] i_op = 7'd0;
  logic [2:0] i_f3 = 3'd0;
  logic       i_f7 = 1'b0;
  logic       ill_exp = 1'b0;
  logic [3:0] fl_force = 4'b0000;

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ALU operation implied by funct3/funct7b5 for register or immediate arithmetic
  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic rtype);
    case (f3)
      3'd0:    return (rtype && f7) ? 4'd1 : 4'd0;
      3'd1:    return 4'd8;
      3'd2:    return 4'd6;
      3'd3:    return 4'd5;
      3'd4:    return 4'd4;
      3'd5:    return f7 ? 4'd10 : 4'd9;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    if (o == 7'b0100011) return 3'd1;
    if (o == 7'b1100011) return 3'd2;
    if (o == 7'b1101111) return 3'd3;
    if (o == 7'b0110111 || o == 7'b0010111) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic branch_ref(input logic [2:0] f3);
    case (f3)
      3'd0:    return Zero;
      3'd1:    return !Zero;
      3'd4:    return signedLess;
      3'd5:    return !signedLess;
      3'd6:    return unsignedLess;
      3'd7:    return !unsignedLess;
      default: return 1'b0;
    endcase
  endfunction

  function automatic out_t expect_out(input phase_t ph, input logic mr, input logic r);
    out_t o;
    o     = '0;
    o.imm = imm_ref(i_op);
    o.ill = ill_exp;
    case (ph)
      P_FETCH:    begin o.sb = 2; o.rs = 2; o.irw = mr; o.pcw = mr; end
      P_DECODE:   begin o.sa = 1; o.sb = 1; end
      P_MEMADR:   begin o.sa = 2; o.sb = 1; end
      P_MEMREAD:  o.adr = 1;
      P_MEMWB:    begin o.rs = 1; o.rw = 1; end
      P_MEMWRITE: begin o.adr = 1; o.mw = 1; end
      P_EXECR:    begin o.sa = 2; o.alu = alu_ref(i_f3, i_f7, 1'b1); end
      P_EXECI:    begin o.sa = 2; o.sb = 1; o.alu = alu_ref(i_f3, i_f7, 1'b0); end
      P_ALUWB:    o.rw = 1;
      P_BRANCH:   begin o.sa = 2; o.alu = 4'd1; o.pcw = branch_ref(i_f3); end
      P_JALR:     begin o.sa = 2; o.sb = 1; end
      P_JAL:      begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      P_UPPER:    begin
        o.sb = 1;
        if (i_op == 7'b0110111) o.alu = 4'd7;
        else o.sa = 1;
      end
      default:    ;
    endcase
    if (r) begin o.pcw = 0; o.mw = 0; o.irw = 0; o.rw = 0; end
    return o;
  endfunction

  // One clock cycle spent in phase ph; r=1 requests reset at the closing edge.
  task automatic step(input phase_t ph, input logic mr, input logic r);
    @(posedge clk); #1;
    op = i_op; funct3 = i_f3; funct7b5 = i_f7;
    mem_ready = mr; rst = r;
    if (fl_force[3]) {Zero, signedLess, unsignedLess} = fl_force[2:0];
    else {Zero, signedLess, unsignedLess} = 3'($urandom_range(0, 7));
    if (ph == P_HALT) ill_exp = 1'b1;
    q_exp.push_back(expect_out(ph, mr, r));
    q_ph.push_back(ph);
    if (r) ill_exp = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int unsigned fst, input int unsigned mst, input int unsigned hlt);
    i_op = o; i_f3 = f3; i_f7 = f7;
    for (int unsigned k = 0; k < fst; k++) step(P_FETCH, 1'b0, 1'b0);
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, rb(), 1'b0);
    case (o)
      7'b0000011: begin
        step(P_MEMADR, rb(), 1'b0);
        for (int unsigned k = 0; k < mst; k++) step(P_MEMREAD, 1'b0, 1'b0);
        step(P_MEMREAD, 1'b1, 1'b0);
        step(P_MEMWB, rb(), 1'b0);
      end
      7'b0100011: begin
        step(P_MEMADR, rb(), 1'b0);
        for (int unsigned k = 0; k < mst; k++) step(P_MEMWRITE, 1'b0, 1'b0);
        step(P_MEMWRITE, 1'b1, 1'b0);
      end
      7'b0110011: begin step(P_EXECR, rb(), 1'b0); step(P_ALUWB, rb(), 1'b0); end
      7'b0010011: begin step(P_EXECI, rb(), 1'b0); step(P_ALUWB, rb(), 1'b0); end
      7'b1100011: step(P_BRANCH, rb(), 1'b0);
      7'b1101111: begin step(P_JAL, rb(), 1'b0); step(P_ALUWB, rb(), 1'b0); end
      7'b1100111: begin
        step(P_JALR, rb(), 1'b0); step(P_JAL, rb(), 1'b0); step(P_ALUWB, rb(), 1'b0);
      end
      7'b0110111, 7'b0010111: begin step(P_UPPER, rb(), 1'b0); step(P_ALUWB, rb(), 1'b0); end
      default: begin
        for (int unsigned k = 0; k < hlt; k++) step(P_HALT, rb(), 1'b0);
        step(P_HALT, rb(), 1'b1);
      end
    endcase
  endtask

  // monitor: every cycle the DUT presents a full control word
  initial begin
    out_t   act, exp_o;
    phase_t ph;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        exp_o = q_exp.pop_front();
        ph    = q_ph.pop_front();
        act   = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, illegal};
        checks++;
        if (act !== exp_o) begin
          errors++;
          $display("FAIL %s @%0t: got %05h (pcw%b adr%b mw%b irw%b rw%b rs%b sa%b sb%b alu%b imm%b ill%b) expected %05h",
                   ph.name(), $time, act, act.pcw, act.adr, act.mw, act.irw, act.rw,
                   act.rs, act.sa, act.sb, act.alu, act.imm, act.ill, exp_o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] o;
    rst = 1'b1; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; signedLess = 1'b0; unsignedLess = 1'b0;

    step(P_FETCH, 1'b0, 1'b1);
    step(P_FETCH, 1'b1, 1'b1);

    // add x3,x1,x2 with no stalls
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 0);
    // lw with three MEMREAD stall cycles
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 3, 0);
    // blt taken on signedLess, bgeu not taken on unsignedLess
    fl_force = 4'b1010;
    run_instr(7'b1100011, 3'b100, 1'b0, 0, 0, 0);
    fl_force = 4'b1001;
    run_instr(7'b1100011, 3'b111, 1'b0, 0, 0, 0);
    fl_force = 4'b0000;
    // srai, addi with instr[30] set, sub
    run_instr(7'b0010011, 3'b101, 1'b1, 0, 0, 0);
    run_instr(7'b0010011, 3'b000, 1'b1, 0, 0, 0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1, 0, 0);
    // unsupported opcode: HALT for 10 cycles, then reset
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 10);
    // reset while a store waits on memory
    i_op = 7'b0100011; i_f3 = 3'b010; i_f7 = 1'b0;
    step(P_FETCH, 1'b1, 1'b0);
    step(P_DECODE, 1'b1, 1'b0);
    step(P_MEMADR, 1'b0, 1'b0);
    step(P_MEMWRITE, 1'b0, 1'b0);
    step(P_MEMWRITE, 1'b0, 1'b0);
    step(P_MEMWRITE, 1'b0, 1'b1);
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, 0);
    run_instr(7'b0010111, 3'b000, 1'b0, 0, 0, 0);
    run_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 2, 0, 0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do o = 7'($urandom_range(0, 127));
        while (o inside {legal_ops});
      end else begin
        o = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(o, 3'($urandom_range(0, 7)), rb(), $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(1, 3));
    end

    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(negedge clk);
    #1;
    if (q_exp.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", q_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 op  in  7  instr[6:0]; funct3  in  3  instr[14:12]; funct7b5  in  1  instr[30].
REQ-005 Zero, signedLess, unsignedLess  in  1 each  ALU flags, valid same cycle.
REQ-006 mem_ready  in  1  memory completes the access this cycle.
REQ-007 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes.
REQ-008 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-009 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 reg. ALUSrcB  out  2  00 rs2 reg, 01 ImmExt, 10 const 4.
REQ-010 ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sltu, 0110 slt, 0111 passB, 1000 sll, 1001 srl, 1010 sra.
REQ-011 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op.
REQ-012 illegal  out  1  sticky flag: unsupported opcode decoded.

Function
REQ-013 States SHALL be: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, HALT.
REQ-014 Outputs SHALL be Moore decoded from state (except ALUControl, ImmSrc, branch PCWrite); unlisted strobes 0, selects 00, ALUControl 0000.
REQ-015 FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, add, ResultSrc 10; IRWrite and PCWrite only when mem_ready=1; hold FETCH while mem_ready=0.
REQ-016 DECODE: ALUSrcA 01, ALUSrcB 01, add (branch/jal target into ALUOut); next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->UPPER, other->HALT.
REQ-017 MEMADR: ALUSrcA 10, ALUSrcB 01, add; load->MEMREAD, store->MEMWRITE.
REQ-018 MEMREAD: AdrSrc 1, ResultSrc 00; wait for mem_ready, then MEMWB. MEMWB: ResultSrc 01, RegWrite 1 -> FETCH.
REQ-019 MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1 every cycle until mem_ready=1 -> FETCH.
REQ-020 EXECR: ALUSrcA 10, ALUSrcB 00, decoded op -> ALUWB. EXECI: ALUSrcB 01 instead -> ALUWB.
REQ-021 ALUWB: ResultSrc 00, RegWrite 1 -> FETCH.
REQ-022 Op decode by funct3: 000 add (sub only if R-type and funct7b5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7b5 (both types), 110 or, 111 and.
REQ-023 BRANCH: ALUSrcA 10, ALUSrcB 00, sub, ResultSrc 00; PCWrite = taken: beq Zero, bne !Zero, blt signedLess, bge !signedLess, bltu unsignedLess, bgeu !unsignedLess; funct3 010/011 never taken -> FETCH.
REQ-024 JALR: ALUSrcA 10, ALUSrcB 01, add -> JAL. JAL: ALUSrcA 01, ALUSrcB 10, add, ResultSrc 00, PCWrite 1 -> ALUWB.
REQ-025 UPPER: ALUSrcB 01; op 0110111 passB ALUSrcA 00, op 0010111 add ALUSrcA 01 -> ALUWB.
REQ-026 HALT: illegal=1, all strobes 0; remains until reset.

Reset
REQ-027 rst=1 at a clock edge SHALL force FETCH and clear illegal, overriding any state, including mid-wait on mem_ready.
REQ-028 First post-reset cycle SHALL present FETCH outputs; no write strobe asserts during reset cycle.

Structure
REQ-029 Package ctrl_pkg SHALL hold state enum, ALUControl codes, opcode constants, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings.
REQ-030 Combinational sub-module alu_decoder SHALL implement REQ-022 (inputs: alu_op class, funct3, funct7b5, op[5]).

Verification
REQ-031 add x3,x1,x2, mem_ready=1: FETCH,DECODE,EXECR(ALUControl 0000),ALUWB(RegWrite 1); 4 cycles.
REQ-032 lw, mem_ready low 3 cycles in MEMREAD: 3 stall cycles, RegWrite only in MEMWB with ResultSrc 01.
REQ-033 blt with signedLess=1 -> PCWrite 1; bgeu with unsignedLess=1 -> PCWrite 0.
REQ-034 srai (funct3 101, funct7b5 1) -> 1010; addi with funct7b5 1 -> 0000; sub R-type -> 0001.
REQ-035 op 1111111 -> HALT, illegal=1 held 10 cycles; rst -> FETCH, illegal 0.
REQ-036 rst asserted during MEMWRITE stall -> MemWrite 0 next cycle, FETCH outputs.
